// File: rtl/tb_exit_ctrl_pkg.sv
// tb_exit_ctrl_pkg: register offsets, exit FSM state encoding and watchdog exit code for tb_exit_ctrl
package tb_exit_ctrl_pkg;
  localparam logic [1:0] PRINT_OFF = 2'd0;
  localparam logic [1:0] EXIT_OFF = 2'd1;
  localparam logic [1:0] STATUS_OFF = 2'd2;
  localparam logic [1:0] CYCLES_OFF = 2'd3;
  localparam logic [31:0] WDT_EXIT_CODE = 32'hDEAD_0001;
  typedef enum logic [1:0] {
    RUN = 2'd0,
    DRAIN = 2'd1,
    DONE = 2'd2
  } exit_state_e;
endpackage

// File: rtl/tb_exit_ctrl_fifo.sv
// tb_char_fifo: 8-bit sync FIFO (clk, rst_n async low; push/din in, pop in; dout head, full/empty/count status)
module tb_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == FULL_CNT;
    empty = count_q == '0;
    do_push = push & ~full;
    do_pop = pop & ~empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
    count = count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/tb_exit_ctrl.sv
// tb_exit_ctrl: OBI test-control responder (PRINT/EXIT/STATUS/CYCLES window, char FIFO out, sticky pass/fail; watchdog via TB_EXIT_CTRL_WATCHDOG_EN)
module tb_exit_ctrl
  import tb_exit_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] WDT_CYCLES = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic [31:0] exit_code_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  exit_state_e state_q, state_d;
  logic [31:0] exit_code_q, exit_code_d, cycles_q, cycles_d, rdata_q, rdata_d, status;
  logic rvalid_q, rvalid_d, passed_q, passed_d, failed_q, failed_d;
  logic full, empty, push, pop, sel, wr, rd, print_wr, exit_wr, done_now, wdt_fire;
  logic [CW-1:0] count;
  logic [1:0] off;
  logic unused_ok;
  assign unused_ok = ^{be_i[3:1], addr_i[1:0], WDT_CYCLES};
  tb_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wdata_i[7:0]),
    .pop   (pop),
    .dout  (char_o),
    .full  (full),
    .empty (empty),
    .count (count)
  );
`ifdef TB_EXIT_CTRL_WATCHDOG_EN
  logic [31:0] wdt_q, wdt_d;
  assign wdt_fire = state_q == RUN & wdt_q == WDT_CYCLES - 32'd1;
  assign wdt_d = print_wr ? '0 : state_q == RUN ? wdt_q + 32'd1 : wdt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdt_q <= '0;
    else wdt_q <= wdt_d;
`else
  assign wdt_fire = 1'b0;
`endif
  always_comb begin
    sel = addr_i[31:4] == BASE_ADDR[31:4];
    off = addr_i[3:2];
    gnt_o = req_i & ~(we_i & sel & off == PRINT_OFF & full & state_q == RUN);
    wr = gnt_o & we_i & sel;
    rd = gnt_o & ~we_i & sel;
    print_wr = wr & off == PRINT_OFF;
    exit_wr = wr & off == EXIT_OFF & state_q == RUN;
    push = print_wr & be_i[0] & state_q == RUN;
    pop = ~empty & char_ready_i;
    status = {14'd0, state_q, 8'(count), 6'd0, empty, full};
    rvalid_d = gnt_o;
    rdata_d = ~rd ? '0 : off == STATUS_OFF ? status : off == CYCLES_OFF ? cycles_q : '0;
    cycles_d = cycles_q + 32'd1;
    done_now = state_q == DRAIN & count == '0;
    state_d = exit_wr | wdt_fire ? DRAIN : done_now ? DONE : state_q;
    exit_code_d = exit_wr ? wdata_i : wdt_fire ? WDT_EXIT_CODE : exit_code_q;
    passed_d = passed_q | done_now & ~|exit_code_q;
    failed_d = failed_q | done_now & |exit_code_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      exit_code_q <= '0;
      cycles_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      passed_q <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exit_code_q <= exit_code_d;
      cycles_q <= cycles_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      passed_q <= passed_d;
      failed_q <= failed_d;
    end
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
  assign char_valid_o = ~empty;
  assign exit_code_o = exit_code_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
endmodule

// File: doc/tb_exit_ctrl.md
# tb_exit_ctrl

Memory-mapped test-control responder in the RI5CY testbench environment. It answers core data-bus requests (OBI-style) to a small register window, buffers characters the firmware prints, and produces the `tests_passed_o` / `tests_failed_o` pulses the testbench top monitors to end simulation. It is the device-side end of the pass/fail handshake the testbench consumes.

## Interface

**Parameters**
- `BASE_ADDR`, default `32'h1000_0000`: base of the 16-byte register window.
- `FIFO_DEPTH`, default `8`: print FIFO entries; must be a power of 2 and ≥2.
- `WDT_CYCLES`, default `32'd10_000_000`: watchdog limit in cycles.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `req_i`, in, 1: bus request.
- `gnt_o`, out, 1: grant (combinational).
- `addr_i`, in, 32: byte address.
- `we_i`, in, 1: write enable.
- `be_i`, in, 4: byte enables.
- `wdata_i`, in, 32: write data.
- `rvalid_o`, out, 1: response valid.
- `rdata_o`, out, 32: read data (registered).
- `char_valid_o`, out, 1: FIFO head valid.
- `char_o`, out, 8: FIFO head character.
- `char_ready_i`, in, 1: console sink accepts the character.
- `exit_code_o`, out, 32: latched exit code.
- `tests_passed_o`, out, 1: sticky pass.
- `tests_failed_o`, out, 1: sticky fail.

## Operation

**Address decode**
- The window is selected when `addr_i[31:4] == BASE_ADDR[31:4]`; `addr_i[3:2]` selects the register:
  - 0 `PRINT` (W)
  - 1 `EXIT` (W)
  - 2 `STATUS` (R): bit0 = full, bit1 = empty, bits[15:8] = count, bits[17:16] = FSM state
  - 3 `CYCLES` (R): 32-bit free-running cycle counter, wraps, starts at 0 after reset.
- Reads of W-only registers, and any out-of-window access, are granted. Such reads return 0; such writes are ignored.

**Grant**
- `gnt_o = req_i & ~(we_i & sel_PRINT & full & state==RUN)`. A PRINT write to a full FIFO stalls until a pop occurs.

**PRINT**
- A granted write with `be_i[0]=1` in RUN pushes `wdata_i[7:0]`.
- With `be_i[0]=0`, the write is a no-op.
- In DRAIN or DONE, PRINT writes are granted and discarded.

**FIFO**
- `char_valid_o = ~empty`; `char_o` = head entry.
- A pop occurs on `char_valid_o & char_ready_i`.
- Simultaneous push and pop leaves the count unchanged. A push and pop on a full FIFO in the same cycle is legal: the grant is gated by registered `full`, so the push waits one cycle.

**Exit FSM (RUN → DRAIN → DONE)**
- **RUN:** a granted EXIT write latches `exit_code_o <= wdata_i` and moves to DRAIN.
- **DRAIN:** moves to DONE in the first cycle where count == 0.
- **DONE:** terminal until reset. Sets `tests_passed_o = (exit_code_o == 0)` and `tests_failed_o = (exit_code_o != 0)`; both are sticky.
- Only the first EXIT write counts; EXIT writes in DRAIN or DONE are ignored.

## Timing

- **Reset values:** all outputs 0; FSM in RUN; FIFO empty; counters 0.
- **Response:** `rvalid_o` asserts exactly one cycle after each grant, for reads and writes. `rdata_o` is valid in that same cycle; for writes it is 0.
- **Push visibility:** a push granted at edge N is visible on `char_valid_o` after edge N.
- **Exit, FIFO empty:** EXIT granted at edge N → state DRAIN after N → DONE after N+1. `tests_*_o` are high from cycle N+1 onward.
- **Exit, FIFO non-empty:** DONE occurs one cycle after the count reaches 0.
- **Reset mid-operation:** the asynchronous reset clears the FIFO, FSM, latched exit code and any pending `rvalid_o` immediately.

## Configuration

- **`TB_EXIT_CTRL_WATCHDOG_EN` defined:** a 32-bit watchdog counter increments in RUN and is cleared by any granted PRINT write.
  - When it reaches `WDT_CYCLES-1` in RUN, `exit_code_o <= 32'hDEAD_0001` and the FSM moves to DRAIN.
  - An EXIT write in the same cycle takes priority.
- **Undefined:** no watchdog logic; the FSM leaves RUN only on an EXIT write. The `CYCLES` register exists in both builds.

## Structure

- **Package `tb_exit_ctrl_pkg`:**
  - Register offsets `PRINT_OFF`, `EXIT_OFF`, `STATUS_OFF`, `CYCLES_OFF`.
  - State enum `exit_state_e` = {RUN=0, DRAIN=1, DONE=2}.
  - Constant `WDT_EXIT_CODE = 32'hDEAD_0001`.
- **Sub-module `tb_char_fifo`:** synchronous FIFO, parameter `DEPTH`, width 8, with `push/pop/full/empty/count` ports. The top level holds decode, response register, FSM and counters.

## Test plan

- **Print:** write `0x41`, `0x42` to PRINT with `char_ready_i=1` → `char_o` shows `0x41` then `0x42` on consecutive cycles; `rvalid_o` pulses once per write.
- **Backpressure:** hold `char_ready_i=0` and write 9 chars (`FIFO_DEPTH=8`) → 9th write has `gnt_o=0` until `char_ready_i=1`. STATUS reads `count=8`, `full=1`.
- **Pass after drain:** 3 chars queued with `char_ready_i=0`, then EXIT `0` → state DRAIN, `tests_passed_o=0`. Release ready → pass asserts one cycle after the 3rd pop; `tests_failed_o` stays 0.
- **Fail, first exit wins:** EXIT `0x5` then EXIT `0` → `exit_code_o=5`, `tests_failed_o=1`, `tests_passed_o=0`.
- **Watchdog:** with `TB_EXIT_CTRL_WATCHDOG_EN` defined and `WDT_CYCLES=100`, do no writes → `exit_code_o=0xDEAD_0001` and `tests_failed_o=1` at cycle 101 after reset.
- **Reset and misc accesses:** reset asserted in DRAIN → all outputs 0 immediately. Read CYCLES twice, 10 cycles apart → difference 10. Out-of-window read → `rdata_o=0`, `rvalid_o=1`.
